tdm_demux_2ch: RTL and testbench
================================

// Module: tdm_demux_2ch
// PURPOSE
//  Receive end of a 2-channel time-division multiplexed link. It takes an
//  interleaved stream of slot-0/slot-1 samples, marked by a start-of-frame
//  flag, and routes each sample to a registered per-channel output with a
//  valid strobe. Sits after the 2:1 selection stage. It recovers and checks
//  frame alignment and counts completed frames.
// PARAMETERS
//  W      1  sample width in bits (1 = single-bit channels, as at the mux input)
//  CNT_W  8  width of the completed-frame counter
// PORTS
//  clk          in   1      system clock, all logic rising-edge
//  rst_n        in   1      asynchronous active-low reset
//  din          in   W      multiplexed sample
//  din_valid    in   1      din carries a sample this cycle
//  din_sof      in   1      sample is slot 0 (start of frame); qualified by din_valid
//  clear_err    in   1      synchronous clear of sync_err
//  out0         out  W      last slot-0 sample, held between updates
//  out1         out  W      last slot-1 sample, held between updates
//  out0_valid   out  1      1-cycle pulse: out0 updated this cycle
//  out1_valid   out  1      1-cycle pulse: out1 updated this cycle
//  frame_valid  out  1      1-cycle pulse: aligned slot0+slot1 pair completed
//  frame_cnt    out  CNT_W  completed-frame count, wraps at 2^CNT_W
//  sync_err     out  1      sticky: alignment violation seen
//  locked       out  1      1 when FSM is not in HUNT
// BEHAVIOUR
//  - Reset (rst_n=0, any time, incl. mid-frame): every output is 0 and the
//    FSM goes to HUNT. This takes effect immediately, without a clock edge.
//  - All outputs are registered. Latency from the sampled input beat to the
//    output update/pulse is 1 clk.
//  - din_sof is ignored when din_valid=0. Cycles with din_valid=0 change no
//    state and produce no pulses.
//  - FSM states: HUNT, EXP1 (slot 1 expected), EXP0 (slot 0 expected).
//    Each transition below applies to a valid beat:
//    HUNT, sof=1 -> out0<=din, out0_valid, go EXP1
//    HUNT, sof=0 -> beat dropped, stay HUNT, no error
//    EXP1, sof=0 -> out1<=din, out1_valid, frame_valid, frame_cnt+1, go EXP0
//    EXP1, sof=1 -> sync_err<=1, out0<=din, out0_valid, stay EXP1 (resync;
//                   the previous slot 0 is abandoned, no frame_valid)
//    EXP0, sof=1 -> out0<=din, out0_valid, go EXP1
//    EXP0, sof=0 -> sync_err<=1, beat dropped, go HUNT
//  - frame_cnt wraps from 2^CNT_W-1 to 0 with no flag.
//  - sync_err is set only by the two error transitions above and is cleared
//    only by clear_err=1 or by reset. If clear_err and a new error occur in
//    the same cycle, the error wins and sync_err stays 1.
//  - out0_valid and out1_valid are never high in the same cycle.
//    frame_valid is high only together with out1_valid.
//  - out0 and out1 hold their values through HUNT and errors. Only the
//    transitions above update them.
// TESTING
//  1 Reset then beats (sof,din) = (1,1),(0,0),(1,0),(0,1), W=1 ->
//    out0/out1 = 1/0 then 0/1; frame_valid pulses 2x; frame_cnt=2; sync_err=0.
//  2 Beats with sof=0 first, x3, then (1,1),(0,1) -> no pulses and locked=0
//    for the first 3 beats; locked=1 after the sof beat; one frame_valid;
//    sync_err=0.
//  3 (1,0),(1,1),(0,0) -> sync_err=1 after the 2nd beat and out0=1; then
//    one frame_valid; frame_cnt=1.
//  4 Aligned frame, then a sof=0 beat in EXP0 -> sync_err=1, locked=0;
//    clear_err pulse -> sync_err=0; clear_err in the same cycle as a new
//    error -> sync_err stays 1.
//  5 CNT_W=2, 5 aligned frames -> frame_cnt sequence 1,2,3,0,1.
//  6 Assert rst_n=0 between slot 0 and slot 1 -> all outputs 0 at once;
//    after release, a sof=0 beat gives no pulse and no sync_err.

Source files
------------

// File: rtl/tdm_demux_2ch_if.sv
// Bus bundle for the 2-channel TDM demultiplexer: multiplexed input beat
// plus the per-channel outputs and frame/alignment status.
interface tdm_demux_2ch_if #(
  parameter int unsigned W     = 1,
  parameter int unsigned CNT_W = 8
);
  logic [W-1:0]     din;
  logic             din_valid;
  logic             din_sof;
  logic             clear_err;
  logic [W-1:0]     out0;
  logic [W-1:0]     out1;
  logic             out0_valid;
  logic             out1_valid;
  logic             frame_valid;
  logic [CNT_W-1:0] frame_cnt;
  logic             sync_err;
  logic             locked;

  modport master (
    output din, din_valid, din_sof, clear_err,
    input  out0, out1, out0_valid, out1_valid, frame_valid, frame_cnt,
           sync_err, locked
  );

  modport slave (
    input  din, din_valid, din_sof, clear_err,
    output out0, out1, out0_valid, out1_valid, frame_valid, frame_cnt,
           sync_err, locked
  );
endinterface

// File: rtl/tdm_demux_2ch.sv
// Receive side of a 2-slot TDM link: recovers frame alignment from the SOF
// flag, routes slot samples to registered channel outputs and counts frames.
module tdm_demux_2ch #(
  parameter int unsigned W     = 1,
  parameter int unsigned CNT_W = 8
) (
  input logic             clk,
  input logic             rst_n,
  tdm_demux_2ch_if.slave  bus
);

  localparam int unsigned ST_W = 2;
  localparam logic [ST_W-1:0] ST_HUNT = 2'd0;
  localparam logic [ST_W-1:0] ST_EXP1 = 2'd1;
  localparam logic [ST_W-1:0] ST_EXP0 = 2'd2;

  logic [ST_W-1:0]  state_q, state_d;
  logic [W-1:0]     out0_q, out0_d;
  logic [W-1:0]     out1_q, out1_d;
  logic             out0_v_q, out0_v_d;
  logic             out1_v_q, out1_v_d;
  logic             frame_v_q, frame_v_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             locked_q, locked_d;

  // Next-state: only valid beats move the FSM; a new error overrides clear_err.
  always_comb begin
    state_d   = state_q;
    out0_d    = out0_q;
    out1_d    = out1_q;
    out0_v_d  = 1'b0;
    out1_v_d  = 1'b0;
    frame_v_d = 1'b0;
    cnt_d     = cnt_q;
    err_d     = bus.clear_err ? 1'b0 : err_q;

    if (bus.din_valid) begin
      case (state_q)
        ST_HUNT: begin
          if (bus.din_sof) begin
            out0_d   = bus.din;
            out0_v_d = 1'b1;
            state_d  = ST_EXP1;
          end
        end
        ST_EXP1: begin
          if (bus.din_sof) begin
            // Resync onto the new slot 0; the pending one is abandoned.
            err_d    = 1'b1;
            out0_d   = bus.din;
            out0_v_d = 1'b1;
          end else begin
            out1_d    = bus.din;
            out1_v_d  = 1'b1;
            frame_v_d = 1'b1;
            cnt_d     = cnt_q + CNT_W'(1);
            state_d   = ST_EXP0;
          end
        end
        ST_EXP0: begin
          if (bus.din_sof) begin
            out0_d   = bus.din;
            out0_v_d = 1'b1;
            state_d  = ST_EXP1;
          end else begin
            err_d   = 1'b1;
            state_d = ST_HUNT;
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end

    locked_d = (state_d != ST_HUNT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_HUNT;
      out0_q    <= '0;
      out1_q    <= '0;
      out0_v_q  <= 1'b0;
      out1_v_q  <= 1'b0;
      frame_v_q <= 1'b0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      out0_q    <= out0_d;
      out1_q    <= out1_d;
      out0_v_q  <= out0_v_d;
      out1_v_q  <= out1_v_d;
      frame_v_q <= frame_v_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      locked_q  <= locked_d;
    end
  end

  assign bus.out0        = out0_q;
  assign bus.out1        = out1_q;
  assign bus.out0_valid  = out0_v_q;
  assign bus.out1_valid  = out1_v_q;
  assign bus.frame_valid = frame_v_q;
  assign bus.frame_cnt   = cnt_q;
  assign bus.sync_err    = err_q;
  assign bus.locked      = locked_q;

endmodule

// File: tb/tb_tdm_demux_2ch.sv
// Self-checking bench for tdm_demux_2ch: a 2-bit-counter instance and an
// 8-bit-counter instance share one input stream.
module tb_tdm_demux_2ch;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  tdm_demux_2ch_if #(.W(1), .CNT_W(2)) bus ();
  tdm_demux_2ch_if #(.W(1), .CNT_W(8)) bus8 ();

  assign bus8.din       = bus.din;
  assign bus8.din_valid = bus.din_valid;
  assign bus8.din_sof   = bus.din_sof;
  assign bus8.clear_err = bus.clear_err;

  tdm_demux_2ch #(.W(1), .CNT_W(2)) u_dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  tdm_demux_2ch #(.W(1), .CNT_W(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

  typedef struct packed {
    logic       o0, o1, v0, v1, fv;
    logic [7:0] cnt;
    logic       err, lk;
  } exp_t;

  typedef struct packed {
    logic       rst_first;
    logic       v, s, d, c;
    logic       o0, o1, fv;
    logic [7:0] cnt;
    logic       err, lk;
  } vec_t;

  int errors = 0;
  int checks = 0;
  exp_t sb[$];

  // Reference model: 0 = HUNT, 1 = slot 1 expected, 2 = slot 0 expected
  int         m_st;
  logic       m_o0, m_o1, m_err;
  logic [7:0] m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_o0 = 1'b0; m_o1 = 1'b0; m_err = 1'b0; m_cnt = 8'd0;
    sb.delete();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " out0"}, 32'(bus.out0), 32'd0);
    chk({tag, " out1"}, 32'(bus.out1), 32'd0);
    chk({tag, " v0"}, 32'(bus.out0_valid), 32'd0);
    chk({tag, " v1"}, 32'(bus.out1_valid), 32'd0);
    chk({tag, " fv"}, 32'(bus.frame_valid), 32'd0);
    chk({tag, " cnt"}, 32'(bus.frame_cnt), 32'd0);
    chk({tag, " cnt8"}, 32'(bus8.frame_cnt), 32'd0);
    chk({tag, " err"}, 32'(bus.sync_err), 32'd0);
    chk({tag, " lk"}, 32'(bus.locked), 32'd0);
  endtask

  task automatic do_reset();
    bus.din_valid = 1'b0; bus.din_sof = 1'b0; bus.din = 1'b0; bus.clear_err = 1'b0;
    rst_n = 1'b0;
    #1;
    check_zero("reset");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drive one cycle, push the model's expectation, then pop and compare.
  task automatic step(input logic v, input logic s, input logic d, input logic c,
                      input string tag);
    exp_t e, g;
    e = '0;
    bus.din_valid = v; bus.din_sof = s; bus.din = d; bus.clear_err = c;
    if (c) m_err = 1'b0;
    if (v) begin
      if (m_st == 0) begin
        if (s) begin m_o0 = d; e.v0 = 1'b1; m_st = 1; end
      end else if (m_st == 1) begin
        if (s) begin
          m_err = 1'b1; m_o0 = d; e.v0 = 1'b1;
        end else begin
          m_o1 = d; e.v1 = 1'b1; e.fv = 1'b1; m_cnt = m_cnt + 8'd1; m_st = 2;
        end
      end else begin
        if (s) begin m_o0 = d; e.v0 = 1'b1; m_st = 1; end
        else begin m_err = 1'b1; m_st = 0; end
      end
    end
    e.o0 = m_o0; e.o1 = m_o1; e.cnt = m_cnt; e.err = m_err; e.lk = (m_st != 0);
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      errors++; checks++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      g = sb.pop_front();
      chk({tag, " out0"}, 32'(bus.out0), 32'(g.o0));
      chk({tag, " out1"}, 32'(bus.out1), 32'(g.o1));
      chk({tag, " v0"}, 32'(bus.out0_valid), 32'(g.v0));
      chk({tag, " v1"}, 32'(bus.out1_valid), 32'(g.v1));
      chk({tag, " fv"}, 32'(bus.frame_valid), 32'(g.fv));
      chk({tag, " cnt"}, 32'(bus.frame_cnt), 32'(g.cnt[1:0]));
      chk({tag, " cnt8"}, 32'(bus8.frame_cnt), 32'(g.cnt));
      chk({tag, " err"}, 32'(bus.sync_err), 32'(g.err));
      chk({tag, " lk"}, 32'(bus.locked), 32'(g.lk));
      chk({tag, " v0&v1"}, 32'(bus.out0_valid & bus.out1_valid), 32'd0);
    end
  endtask

  vec_t vecs[9];
  logic [1:0] cnt_seq[5];

  initial begin
    // Hand-derived vectors: basic aligned stream, then a resync.
    vecs[0] = '{1'b1, 1'b1,1'b1,1'b1,1'b0, 1'b1,1'b0,1'b0, 8'd0, 1'b0,1'b1};
    vecs[1] = '{1'b0, 1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b1, 8'd1, 1'b0,1'b1};
    vecs[2] = '{1'b0, 1'b1,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0, 8'd1, 1'b0,1'b1};
    vecs[3] = '{1'b0, 1'b1,1'b0,1'b1,1'b0, 1'b0,1'b1,1'b1, 8'd2, 1'b0,1'b1};
    vecs[4] = '{1'b0, 1'b0,1'b1,1'b1,1'b0, 1'b0,1'b1,1'b0, 8'd2, 1'b0,1'b1};
    vecs[5] = '{1'b1, 1'b1,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0, 8'd0, 1'b0,1'b1};
    vecs[6] = '{1'b0, 1'b1,1'b1,1'b1,1'b0, 1'b1,1'b0,1'b0, 8'd0, 1'b1,1'b1};
    vecs[7] = '{1'b0, 1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b1, 8'd1, 1'b1,1'b1};
    vecs[8] = '{1'b0, 1'b0,1'b0,1'b0,1'b1, 1'b1,1'b0,1'b0, 8'd1, 1'b0,1'b1};
    cnt_seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    rst_n = 1'b1;
    bus.din_valid = 1'b0; bus.din_sof = 1'b0; bus.din = 1'b0; bus.clear_err = 1'b0;
    model_reset();
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      if (vecs[i].rst_first) do_reset();
      step(vecs[i].v, vecs[i].s, vecs[i].d, vecs[i].c, $sformatf("vec%0d", i));
      chk($sformatf("tbl%0d out0", i), 32'(bus.out0), 32'(vecs[i].o0));
      chk($sformatf("tbl%0d out1", i), 32'(bus.out1), 32'(vecs[i].o1));
      chk($sformatf("tbl%0d fv", i), 32'(bus.frame_valid), 32'(vecs[i].fv));
      chk($sformatf("tbl%0d cnt8", i), 32'(bus8.frame_cnt), 32'(vecs[i].cnt));
      chk($sformatf("tbl%0d err", i), 32'(bus.sync_err), 32'(vecs[i].err));
      chk($sformatf("tbl%0d lk", i), 32'(bus.locked), 32'(vecs[i].lk));
    end

    // Hunting: non-SOF beats are dropped silently until a SOF arrives
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b1, 1'b0, "hunt");
      chk("hunt locked", 32'(bus.locked), 32'd0);
    end
    step(1'b1, 1'b1, 1'b1, 1'b0, "hunt sof");
    chk("hunt sof locked", 32'(bus.locked), 32'd1);
    step(1'b1, 1'b0, 1'b1, 1'b0, "hunt s1");
    chk("hunt fv", 32'(bus.frame_valid), 32'd1);
    chk("hunt err", 32'(bus.sync_err), 32'd0);

    // Missing SOF drops lock; clear_err; error beats a simultaneous clear
    do_reset();
    step(1'b1, 1'b1, 1'b1, 1'b0, "e0");
    step(1'b1, 1'b0, 1'b0, 1'b0, "e1");
    step(1'b1, 1'b0, 1'b1, 1'b0, "e2");
    chk("lost err", 32'(bus.sync_err), 32'd1);
    chk("lost lk", 32'(bus.locked), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1, "clr");
    chk("clr err", 32'(bus.sync_err), 32'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0, "e3");
    step(1'b1, 1'b1, 1'b1, 1'b1, "clr+err");
    chk("clr+err err", 32'(bus.sync_err), 32'd1);

    // Narrow counter wraps silently
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 1'(i), 1'b0, "wrap s0");
      step(1'b1, 1'b0, 1'(~i), 1'b0, "wrap s1");
      chk($sformatf("wrap cnt%0d", i), 32'(bus.frame_cnt), 32'(cnt_seq[i]));
    end

    // Asynchronous reset between slot 0 and slot 1
    do_reset();
    step(1'b1, 1'b1, 1'b1, 1'b0, "mid s0");
    rst_n = 1'b0;
    #1;
    check_zero("midrst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 1'b1, 1'b0, "post rst");
    chk("post rst v1", 32'(bus.out1_valid), 32'd0);
    chk("post rst err", 32'(bus.sync_err), 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) == 0), "rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
